// File: rtl/light_panel_frontend_pkg.sv
// Shared definitions for the light panel front end: click event encoding and
// issue FSM state codes. The event encoding matches what LightSystem expects.
// Ports: none (package).
package light_panel_frontend_pkg;

    // Click event encoding stored in the event queue
    localparam logic EV_ON  = 1'b1;
    localparam logic EV_OFF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/light_panel_frontend_btn_debounce.sv
// Two-flop synchronizer plus debounce for one raw panel input; level_o is the
// accepted level, rise_o pulses for one cycle in the cycle level_o goes 0->1.
// Ports: clk_i, reset_ni (sync active-low), raw_i -> level_o, rise_o.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == stable_q) begin
                // any agreeing sample restarts the hold window
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // mismatch held for DEBOUNCE_CYCLES samples: accept new level
                stable_q <= sync2_q;
                rise_q   <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/light_panel_frontend.sv
// Wall-panel front end: debounces ON/OFF buttons and keypad, queues press events
// (2 deep) and issues them as paced one-cycle onClick/offClick pulses while the
// controller reports waiting. Also registers lampstate onto the panel LED.
// Ports: clk, reset (sync active-low), btn_on_raw, btn_off_raw, keypad_raw,
//        waiting, lampstate -> onClick, offClick, keypad, lamp_led, pending[1:0], dropped.
module light_panel_frontend
    import light_panel_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_on_raw,
    input  logic       btn_off_raw,
    input  logic       keypad_raw,
    input  logic       waiting,
    input  logic       lampstate,
    output logic       onClick,
    output logic       offClick,
    output logic       keypad,
    output logic       lamp_led,
    output logic [1:0] pending,
    output logic       dropped
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic on_level, on_rise, off_level, off_rise, kp_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_on (
        .clk_i(clk), .reset_ni(reset), .raw_i(btn_on_raw),
        .level_o(on_level), .rise_o(on_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_off (
        .clk_i(clk), .reset_ni(reset), .raw_i(btn_off_raw),
        .level_o(off_level), .rise_o(off_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_kp (
        .clk_i(clk), .reset_ni(reset), .raw_i(keypad_raw),
        .level_o(keypad), .rise_o(kp_rise)
    );

    // Event queue: ent_q[0] is the head, cnt_q the occupancy
    logic [1:0] ent_q, ent_d;
    logic [1:0] cnt_q, cnt_d, cnt_after_pop;
    logic       dropped_q;
    logic       ev_vld, ev_dat, pop, push_ok, drop;

    issue_state_e     state_q;
    logic             on_q, off_q, led_q;
    logic [GAP_W-1:0] gap_q;

    always_comb begin
        ev_vld        = on_rise | off_rise;
        // simultaneous presses: OFF wins, ON discarded without flagging a drop
        ev_dat        = off_rise ? EV_OFF : EV_ON;
        pop           = (state_q == ST_ISSUE);
        cnt_after_pop = cnt_q - {1'b0, pop};
        // a pop in the same cycle frees a slot for the push
        push_ok       = ev_vld && (cnt_after_pop != 2'd2);
        drop          = ev_vld && !push_ok;
        ent_d         = ent_q;
        if (pop) begin
            ent_d[0] = ent_q[1];
        end
        if (push_ok) begin
            ent_d[cnt_after_pop[0]] = ev_dat;
        end
        cnt_d = cnt_after_pop + {1'b0, push_ok};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_q     <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            ent_q     <= ent_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_q | drop;
            led_q     <= lampstate;
        end
    end

    // Issue FSM with registered click outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            on_q  <= 1'b0;
            off_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q != 2'd0 && waiting) begin
                        state_q <= ST_ISSUE;
                        on_q    <= (ent_q[0] == EV_ON);
                        off_q   <= (ent_q[0] == EV_OFF);
                    end
                end
                ST_ISSUE: begin
                    gap_q   <= GAP_W'(GAP_CYCLES - 1);
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign onClick  = on_q;
    assign offClick = off_q;
    assign lamp_led = led_q;
    assign pending  = cnt_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_light_panel_frontend.sv
module tb_light_panel_frontend;

    localparam int DB  = 4;
    localparam int CW  = 5;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_on_raw = 1'b0, btn_off_raw = 1'b0, keypad_raw = 1'b0;
    logic       waiting = 1'b0, lampstate = 1'b0;
    logic       onClick, offClick, keypad, lamp_led, dropped;
    logic [1:0] pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_panel_frontend #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .btn_on_raw(btn_on_raw), .btn_off_raw(btn_off_raw), .keypad_raw(keypad_raw),
        .waiting(waiting), .lampstate(lampstate),
        .onClick(onClick), .offClick(offClick), .keypad(keypad), .lamp_led(lamp_led),
        .pending(pending), .dropped(dropped)
    );

    // ---------------- reference model ----------------
    // Input acceptance: a level is accepted once the last DB synchronized samples
    // (raw delayed by two clocks) all differ from the current accepted level.
    // Clicks: a queue of events; an issue is allowed when the queue is non-empty,
    // waiting is high, and at least GAP+2 clocks have passed since the last issue.
    int               cyc = 0;
    bit [DB+1:0]      h_on, h_off, h_kp;  // bit k = raw sampled k clocks ago
    bit               st_on, st_off, st_kp, rise_on, rise_off;
    bit               q[$];
    bit               m_on, m_off, m_drop, m_led, pop_next;
    int               last_iss;

    always @(posedge clk) begin
        bit do_pop;
        cyc++;
        if (!reset) begin
            h_on = '0; h_off = '0; h_kp = '0;
            st_on = 0; st_off = 0; st_kp = 0; rise_on = 0; rise_off = 0;
            q.delete();
            m_on = 0; m_off = 0; m_drop = 0; m_led = 0; pop_next = 0;
            last_iss = -100;
        end else begin
            m_on = 0; m_off = 0;
            do_pop = pop_next;
            pop_next = 0;
            if (cyc - last_iss >= GAP + 2 && q.size() > 0 && waiting) begin
                if (q[0]) m_on = 1; else m_off = 1;
                last_iss = cyc;
                pop_next = 1;
            end
            if (do_pop) void'(q.pop_front());
            if (rise_on || rise_off) begin
                if (q.size() < 2) q.push_back(rise_off ? 1'b0 : 1'b1);
                else m_drop = 1;
            end
            h_on  = {h_on[DB:0], btn_on_raw};
            h_off = {h_off[DB:0], btn_off_raw};
            h_kp  = {h_kp[DB:0], keypad_raw};
            rise_on = 0; rise_off = 0;
            if (h_on[DB+1:2] == {DB{~st_on}}) begin st_on = ~st_on; rise_on = st_on; end
            if (h_off[DB+1:2] == {DB{~st_off}}) begin st_off = ~st_off; rise_off = st_off; end
            if (h_kp[DB+1:2] == {DB{~st_kp}}) st_kp = ~st_kp;
            m_led = lampstate;
        end
    end

    // ---------------- checking helpers ----------------
    int n_on = 0, n_off = 0, last_on = 0, last_off = 0;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("onClick", onClick, m_on);
        chk("offClick", offClick, m_off);
        chk("keypad", keypad, st_kp);
        chk("lamp_led", lamp_led, m_led);
        chk("pending", pending, 2'(q.size()));
        chk("dropped", dropped, m_drop);
        if (onClick === 1'b1) begin n_on++; last_on = cyc; end
        if (offClick === 1'b1) begin n_off++; last_off = cyc; end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic press(input bit is_off);
        if (is_off) btn_off_raw = 1'b1; else btn_on_raw = 1'b1;
        step(8);
        btn_on_raw = 1'b0; btn_off_raw = 1'b0;
        step(8);
    endtask

    // ---------------- stimulus ----------------
    int start, base_on, base_off;

    initial begin
        // Reset with raw inputs toggling
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_on_raw  = 1'($urandom_range(0, 1));
            btn_off_raw = 1'($urandom_range(0, 1));
            keypad_raw  = 1'($urandom_range(0, 1));
            lampstate   = 1'($urandom_range(0, 1));
            step(1);
            chk("rst_onClick", onClick, 2'd0);
            chk("rst_offClick", offClick, 2'd0);
            chk("rst_lamp_led", lamp_led, 2'd0);
            chk("rst_pending", pending, 2'd0);
            chk("rst_dropped", dropped, 2'd0);
        end
        btn_on_raw = 0; btn_off_raw = 0; keypad_raw = 0; lampstate = 0;
        reset = 1'b1;
        step(DB + 4);

        // Clean press: one onClick, 8 clocks after raw rise
        waiting = 1'b1;
        start = cyc; n_on = 0; n_off = 0;
        btn_on_raw = 1'b1;
        step(20);
        btn_on_raw = 1'b0;
        step(DB + 4);
        chk("clean_count", 2'(n_on), 2'd1);
        chk("clean_latency", 2'(last_on - start - 6), 2'd2);
        chk("clean_no_off", 2'(n_off), 2'd0);

        // Bounce: toggles every 2 clocks for 12 clocks, then settles high
        n_off = 0;
        for (int i = 0; i < 12; i++) begin
            btn_off_raw = ((i / 2) % 2 == 0);
            step(1);
        end
        chk("bounce_quiet", 2'(n_off), 2'd0);
        btn_off_raw = 1'b1;
        step(20);
        btn_off_raw = 1'b0;
        step(DB + 4);
        chk("bounce_count", 2'(n_off), 2'd1);

        // Pacing: three presses while controller busy
        waiting = 1'b0;
        n_on = 0; n_off = 0;
        press(1'b0);
        press(1'b1);
        press(1'b0);
        chk("pace_pending", pending, 2'd2);
        chk("pace_dropped", dropped, 2'd1);
        chk("pace_held", 2'(n_on + n_off), 2'd0);
        waiting = 1'b1;
        step(12);
        chk("pace_on", 2'(n_on), 2'd1);
        chk("pace_off", 2'(n_off), 2'd1);
        chk("pace_spacing", 2'(last_off - last_on - 3), 2'd1);
        chk("pace_drained", pending, 2'd0);

        // Simultaneous presses after a reset clears dropped
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        n_on = 0; n_off = 0;
        btn_on_raw = 1'b1; btn_off_raw = 1'b1;
        step(10);
        btn_on_raw = 1'b0; btn_off_raw = 1'b0;
        step(10);
        chk("simul_off", 2'(n_off), 2'd1);
        chk("simul_on", 2'(n_on), 2'd0);
        chk("simul_dropped", dropped, 2'd0);

        // Reset while a click is issuing with another queued
        waiting = 1'b0;
        press(1'b0);
        press(1'b1);
        chk("mid_pending", pending, 2'd2);
        waiting = 1'b1;
        step(1);
        chk("mid_issue", onClick, 2'd1);
        reset = 1'b0;
        base_on = n_on; base_off = n_off;
        step(1);
        chk("mid_rst_pending", pending, 2'd0);
        chk("mid_rst_on", onClick, 2'd0);
        reset = 1'b1;
        lampstate = 1'b1;
        step(1);
        chk("mid_led", lamp_led, 2'd1);
        step(10);
        chk("mid_no_pulse", 2'(n_on + n_off - base_on - base_off), 2'd0);

        // Randomized phase against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 6) == 0) btn_on_raw  = ~btn_on_raw;
            if ($urandom_range(0, 6) == 0) btn_off_raw = ~btn_off_raw;
            if ($urandom_range(0, 4) == 0) keypad_raw  = ~keypad_raw;
            if ($urandom_range(0, 9) == 0) waiting     = ~waiting;
            lampstate = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 299) != 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
